// File: rtl/hilo_muldiv_pkg.sv
// Shared HI/LO unit definitions: ALU control codes (also used by the ALU decoder),
// datapath width, division result struct and small helpers.
package hilo_muldiv_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] MULT_CONTROL  = 5'd16;
    localparam logic [4:0] MULTU_CONTROL = 5'd17;
    localparam logic [4:0] DIV_CONTROL   = 5'd18;
    localparam logic [4:0] DIVU_CONTROL  = 5'd19;
    localparam logic [4:0] MFHI_CONTROL  = 5'd20;
    localparam logic [4:0] MTHI_CONTROL  = 5'd21;
    localparam logic [4:0] MFLO_CONTROL  = 5'd22;
    localparam logic [4:0] MTLO_CONTROL  = 5'd23;

    typedef struct packed {
        logic [DATA_W-1:0] quot;
        logic [DATA_W-1:0] rem;
    } div_res_t;

    function automatic logic is_div_code(input logic [4:0] code);
        return (code == DIV_CONTROL) || (code == DIVU_CONTROL);
    endfunction

    // Magnitude of a two's-complement value; 0x80000000 maps to itself as unsigned.
    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// EX-stage <-> HI/LO unit signal bundle; master is the pipeline, slave the unit.
interface hilo_muldiv_if;
    import hilo_muldiv_pkg::*;

    logic              valid_i;
    logic [4:0]        alucontrol;
    logic [DATA_W-1:0] srca;
    logic [DATA_W-1:0] srcb;
    logic              flush;
    logic              stall_o;
    logic [DATA_W-1:0] hilo_result;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output valid_i, alucontrol, srca, srcb, flush,
        input  stall_o, hilo_result, hi_o, lo_o
    );

    modport slave (
        input  valid_i, alucontrol, srca, srcb, flush,
        output stall_o, hilo_result, hi_o, lo_o
    );

endinterface

// File: rtl/div_iter.sv
// Unsigned radix-2 restoring divider: loads magnitudes on start_i, one step per
// cycle for 32 cycles; done_o flags the cycle in which the final step is taken.
module div_iter
    import hilo_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              done_o,
    output div_res_t          res_o
);

    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W:0]   partial;
    logic [DATA_W:0]   trial;

    // rem_q < dvs_q always holds, so a 33-bit trial difference cannot overflow.
    always_comb begin
        partial = {rem_q, quot_q[DATA_W-1]};
        trial   = partial - {1'b0, dvs_q};
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            quot_d = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!trial[DATA_W]) begin
                rem_d  = trial[DATA_W-1:0];
                quot_d = {quot_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d  = partial[DATA_W-1:0];
                quot_d = {quot_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        quot_q <= quot_d;
        rem_q  <= rem_d;
        dvs_q  <= dvs_d;
    end

    assign done_o = busy_q & (cnt_q == 5'd31) & !abort_i;
    assign res_o  = '{quot: quot_q, rem: rem_q};

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU/MTHI/MTLO, 33-stall DIV/DIVU.
// Build option: define MULDIV_DIVZERO_FAST_EN to finish zero-divisor divisions at once.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hilo_muldiv_if.slave bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

`ifdef MULDIV_DIVZERO_FAST_EN
    localparam bit DIVZ_FAST = 1'b1;
`else
    localparam bit DIVZ_FAST = 1'b0;
`endif

    logic [1:0]               state_q, state_d;
    logic [DATA_W-1:0]        hi_q, hi_d;
    logic [DATA_W-1:0]        lo_q, lo_d;
    logic                     qneg_q, qneg_d;
    logic                     rneg_q, rneg_d;
    logic                     divz_q, divz_d;
    logic [DATA_W-1:0]        dvd_raw_q, dvd_raw_d;

    logic signed [DATA_W-1:0]   opa, opb;
    logic signed [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0]        prod_u;
    logic                       accept, div_go, div_signed, div_zero, div_skip;
    logic                       iter_start, iter_abort, iter_done;
    logic [DATA_W-1:0]          mag_a, mag_b, quot_fix, rem_fix;
    logic [DATA_W-1:0]          result;
    div_res_t                   div_res;

    assign opa    = bus.srca;
    assign opb    = bus.srcb;
    assign prod_s = 64'(opa) * 64'(opb);
    assign prod_u = 64'(bus.srca) * 64'(bus.srcb);

    assign div_signed = (bus.alucontrol == DIV_CONTROL);
    assign div_zero   = (bus.srcb == '0);
    assign div_skip   = DIVZ_FAST & div_zero;
    assign mag_a      = div_signed ? abs_val(bus.srca) : bus.srca;
    assign mag_b      = div_signed ? abs_val(bus.srcb) : bus.srcb;

    assign accept     = bus.valid_i & !bus.flush & (state_q == IDLE);
    assign div_go     = accept & is_div_code(bus.alucontrol);
    assign iter_start = div_go & !div_skip;
    assign iter_abort = bus.flush & (state_q == DIV_RUN);

    div_iter u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (iter_start),
        .abort_i    (iter_abort),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .done_o     (iter_done),
        .res_o      (div_res)
    );

    assign quot_fix = qneg_q ? -div_res.quot : div_res.quot;
    assign rem_fix  = rneg_q ? -div_res.rem  : div_res.rem;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        divz_d    = divz_q;
        dvd_raw_d = dvd_raw_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.alucontrol)
                        MULT_CONTROL:  {hi_d, lo_d} = prod_s;
                        MULTU_CONTROL: {hi_d, lo_d} = prod_u;
                        MTHI_CONTROL:  hi_d = bus.srca;
                        MTLO_CONTROL:  lo_d = bus.srca;
                        DIV_CONTROL, DIVU_CONTROL: begin
                            qneg_d    = div_signed & (bus.srca[DATA_W-1] ^ bus.srcb[DATA_W-1]);
                            rneg_d    = div_signed & bus.srca[DATA_W-1];
                            divz_d    = div_zero;
                            dvd_raw_d = bus.srca;
                            state_d   = div_skip ? DIV_DONE : DIV_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            DIV_RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (iter_done) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_d = IDLE;
                // A zero divisor bypasses the iteration result entirely.
                if (!bus.flush) begin
                    hi_d = divz_q ? dvd_raw_q : rem_fix;
                    lo_d = divz_q ? '1 : quot_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        qneg_q    <= qneg_d;
        rneg_q    <= rneg_d;
        divz_q    <= divz_d;
        dvd_raw_q <= dvd_raw_d;
    end

    always_comb begin
        result = '0;
        if (rst) begin
            case (bus.alucontrol)
                MFHI_CONTROL: result = hi_q;
                MFLO_CONTROL: result = lo_q;
                default:      result = '0;
            endcase
        end
    end

    assign bus.hilo_result = result;
    assign bus.hi_o        = hi_q;
    assign bus.lo_o        = lo_q;
    assign bus.stall_o     = rst & !bus.flush &
                             (((state_q == IDLE) & bus.valid_i & is_div_code(bus.alucontrol)) |
                              (state_q == DIV_RUN));

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit, an asynchronous active-low reset.
REQ-003 The module SHALL have the port valid_i, input, 1 bit, asserted when the EX stage holds a valid instruction.
REQ-004 The module SHALL have the port alucontrol, input, 5 bits, the EX-stage ALU control code.
REQ-005 The module SHALL have the port srca, input, 32 bits, operand rs (dividend, multiplicand, or MTHI/MTLO data).
REQ-006 The module SHALL have the port srcb, input, 32 bits, operand rt (divisor, multiplier).
REQ-007 The module SHALL have the port flush, input, 1 bit, which kills the EX instruction and aborts any division in progress.
REQ-008 The module SHALL have the port stall_o, output, 1 bit, the pipeline stall request.
REQ-009 The module SHALL have the port hilo_result, output, 32 bits, carrying HI for MFHI and LO for MFLO, and 0 for any other code.
REQ-010 The module SHALL have the ports hi_o and lo_o, output, 32 bits each, carrying the architectural HI and LO registers.

Function
REQ-011 An instruction SHALL be accepted when valid_i=1, flush=0 and state=IDLE; only the codes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO (\_CONTROL) SHALL be acted on, and all other codes SHALL leave state unchanged.
REQ-012 MULT and MULTU SHALL write {HI,LO} with the 64-bit signed or unsigned product at the end of the issue cycle, with no stall.
REQ-013 MTHI SHALL write HI=srca, and MTLO SHALL write LO=srca, at the end of the issue cycle.
REQ-014 MFHI and MFLO SHALL drive hilo_result combinationally from the current HI or LO; a read in the cycle after a write SHALL see the new value.
REQ-015 The FSM SHALL have the states IDLE, DIV_RUN and DIV_DONE.
REQ-016 On an accepted DIV or DIVU, the FSM SHALL latch the operand magnitudes (absolute values for DIV) and the sign bits, clear a 5-bit counter, and go IDLE->DIV_RUN.
REQ-017 DIV_RUN SHALL perform one radix-2 restoring step per cycle (32 cycles), then go to DIV_DONE.
REQ-018 DIV_DONE SHALL apply the sign correction, write LO=quotient and HI=remainder, and return to IDLE.
REQ-019 The DIV sign rules SHALL be as follows:
- quotient is negated when the operand signs differ;
- remainder takes the dividend's sign;
- 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-020 A zero divisor SHALL give HI=srca and LO=0xFFFFFFFF for both DIV and DIVU, in every configuration.
REQ-021 stall_o SHALL equal ((IDLE & valid_i & div-code) | DIV_RUN) & !flush, so that a non-zero division gives exactly 33 stall cycles and HI/LO are visible 34 cycles after issue.
REQ-022 stall_o SHALL be low in DIV_DONE, so that the pipeline advances on the edge that writes HI/LO; a div code still present in DIV_DONE SHALL NOT restart.
REQ-023 flush in DIV_RUN or DIV_DONE SHALL return the FSM to IDLE on the next edge with HI and LO unchanged.
REQ-024 flush in the issue cycle SHALL suppress every write.

Reset
REQ-025 While rst=0, the block SHALL immediately set state=IDLE, counter=0, HI=0, LO=0, stall_o=0 and hilo_result=0, including when reset is asserted mid-division.
REQ-026 The first edge after release SHALL be able to accept an instruction.

Configuration
REQ-027 With MULDIV_DIVZERO_FAST_EN defined, a division with srcb==0 SHALL go IDLE->DIV_DONE directly, with stall_o high for the issue cycle only.
REQ-028 Without MULDIV_DIVZERO_FAST_EN, a zero-divisor division SHALL run all 32 steps (33 stall cycles).
REQ-029 With or without MULDIV_DIVZERO_FAST_EN, HI/LO SHALL be identical per REQ-020.

Structure
REQ-030 The control codes (MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO_CONTROL, 5 bits) SHALL come from the shared defines header used by the ALU decoder and SHALL NOT be redefined locally.
REQ-031 FSM state encodings SHALL be defined locally.
REQ-032 The iterative divider datapath (magnitude registers, counter, restoring step) SHALL be a sub-module named div_iter with start/done handshake; the multiplier, HI/LO and FSM SHALL stay in hilo_muldiv.

Verification
REQ-033 MULT 0xFFFFFFFE x 0x00000003 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, stall_o never high; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-034 DIV 0xFFFFFFF9 / 0x00000002 -> stall_o high exactly 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; MFHI in the next instruction returns HI.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5/0 -> HI=5, LO=0xFFFFFFFF, with 1 stall cycle when MULDIV_DIVZERO_FAST_EN is defined and 33 when it is not.
REQ-036 MTHI 0x12345678 then MFHI -> hilo_result=0x12345678; MTLO 0xA5A5A5A5 then MFLO -> hilo_result=0xA5A5A5A5.
REQ-037 flush on the 10th DIV_RUN cycle of DIV 100/7 -> stall_o low the same cycle, FSM IDLE next edge, HI/LO hold their prior values, and a following MTLO is accepted.
REQ-038 rst driven low on the 20th DIV_RUN cycle -> HI=LO=0, stall_o=0 and state IDLE without waiting for a clock edge.
